// File: rtl/rtc_hms_counter_if.sv
// Load handshake bundle for the time-of-day counter: request, BCD payload,
// ready back-pressure and the reject pulse.
interface rtc_hms_counter_if;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_hh;
    logic [7:0] load_mm;
    logic [7:0] load_ss;
    logic       load_err;

    modport master (
        output load_valid, load_hh, load_mm, load_ss,
        input  load_ready, load_err
    );

    modport slave (
        input  load_valid, load_hh, load_mm, load_ss,
        output load_ready, load_err
    );
endinterface

// File: rtl/rtc_hms_counter.sv
// BCD hours/minutes/seconds keeper advanced by edges of the slow 1 Hz divider
// output, sampled in the clk domain, with a validated two-cycle load path.
module rtc_hms_counter #(
    parameter int EDGE_SEL  = 1,
    parameter int HOURS_MAX = 23
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_in,
    input  logic               run,
    rtc_hms_counter_if.slave   ld,
    output logic [7:0]         hh,
    output logic [7:0]         mm,
    output logic [7:0]         ss,
    output logic               sec_pulse,
    output logic               min_pulse,
    output logic               hour_pulse,
    output logic               day_pulse
);

    localparam logic [7:0] HH_MAX_BCD = {4'(HOURS_MAX / 10), 4'(HOURS_MAX % 10)};

    typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_LOAD} state_t;

    state_t     state;
    logic       tick_d;
    logic       ev;
    logic       hs;
    logic       cnt_en;
    logic       stg_ok;
    logic [7:0] stg_hh, stg_mm, stg_ss;
    logic [8:0] ss_inc, mm_inc, hh_inc;

    // {carry, next}: wraps to 00 with carry once the unit reaches its top value
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        if (v == top)
            return 9'h100;
        if (v[3:0] == 4'd9)
            return {1'b0, v[7:4] + 4'd1, 4'd0};
        return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    // Legal digits and not above top; for legal BCD a plain compare is a decimal compare
    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] top);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= top);
    endfunction

    always_comb begin
        ev     = (EDGE_SEL != 0) ? (tick_in & ~tick_d) : (tick_in ^ tick_d);
        hs     = ld.load_valid & ld.load_ready;
        cnt_en = (state == ST_RUN) && ev && !hs;
        ss_inc = bcd_inc(ss, 8'h59);
        mm_inc = bcd_inc(mm, 8'h59);
        hh_inc = bcd_inc(hh, HH_MAX_BCD);
        stg_ok = bcd_ok(stg_ss, 8'h59) && bcd_ok(stg_mm, 8'h59) && bcd_ok(stg_hh, HH_MAX_BCD);
    end

    // Tracks tick_in even during reset so a level already high at release is not an edge
    always_ff @(posedge clk) begin
        tick_d <= tick_in;
    end

    always_ff @(posedge clk) begin
        if (hs) begin
            stg_hh <= ld.load_hh;
            stg_mm <= ld.load_mm;
            stg_ss <= ld.load_ss;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_STOP;
            ld.load_ready <= 1'b1;
            ld.load_err   <= 1'b0;
            hh            <= 8'h00;
            mm            <= 8'h00;
            ss            <= 8'h00;
            sec_pulse     <= 1'b0;
            min_pulse     <= 1'b0;
            hour_pulse    <= 1'b0;
            day_pulse     <= 1'b0;
        end else begin
            sec_pulse   <= 1'b0;
            min_pulse   <= 1'b0;
            hour_pulse  <= 1'b0;
            day_pulse   <= 1'b0;
            ld.load_err <= 1'b0;

            // Cascaded carries are resolved in one edge so all pulses coincide
            if (cnt_en) begin
                ss        <= ss_inc[7:0];
                sec_pulse <= 1'b1;
                if (ss_inc[8]) begin
                    mm        <= mm_inc[7:0];
                    min_pulse <= 1'b1;
                    if (mm_inc[8]) begin
                        hh         <= hh_inc[7:0];
                        hour_pulse <= 1'b1;
                        day_pulse  <= hh_inc[8];
                    end
                end
            end

            if (state == ST_LOAD) begin
                if (stg_ok) begin
                    hh <= stg_hh;
                    mm <= stg_mm;
                    ss <= stg_ss;
                end else begin
                    ld.load_err <= 1'b1;
                end
            end

            if (hs) begin
                state         <= ST_LOAD;
                ld.load_ready <= 1'b0;
            end else begin
                state         <= run ? ST_RUN : ST_STOP;
                ld.load_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rtc_hms_counter.sv
// Randomized and directed bench for rtc_hms_counter; a seconds-of-day model
// predicts both a rising-edge and a both-edge instance every cycle.
module tb_rtc_hms_counter;

    localparam int DAY = 24 * 3600;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, run, tick;
    logic [7:0] hh1, mm1, ss1, hh0, mm0, ss0;
    logic sp1, mp1, hp1, dp1, sp0, mp0, hp0, dp0;

    rtc_hms_counter_if lif1();
    rtc_hms_counter_if lif0();

    rtc_hms_counter #(.EDGE_SEL(1), .HOURS_MAX(23)) dut1 (
        .clk(clk), .rst(rst), .tick_in(tick), .run(run), .ld(lif1.slave),
        .hh(hh1), .mm(mm1), .ss(ss1),
        .sec_pulse(sp1), .min_pulse(mp1), .hour_pulse(hp1), .day_pulse(dp1)
    );

    rtc_hms_counter #(.EDGE_SEL(0), .HOURS_MAX(23)) dut0 (
        .clk(clk), .rst(rst), .tick_in(tick), .run(run), .ld(lif0.slave),
        .hh(hh0), .mm(mm0), .ss(ss0),
        .sec_pulse(sp0), .min_pulse(mp0), .hour_pulse(hp0), .day_pulse(dp0)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: time as seconds since midnight; index 1 = rising-edge unit
    int   m_secs [2];
    bit   m_sp [2], m_mp [2], m_hp [2], m_dp [2];
    bit   m_err, m_prev, m_loading, m_running;
    logic [7:0] m_shh, m_smm, m_sss;

    int cnt_sp1, cnt_sp0, cnt_mp1, cnt_err1, all_pulses1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) % 10) * 16 + (v % 10));
    endfunction

    function automatic bit legal(input logic [7:0] b, input int lim);
        int hi, lo;
        hi = int'(b[7:4]);
        lo = int'(b[3:0]);
        return (hi <= 9) && (lo <= 9) && (hi * 10 + lo <= lim);
    endfunction

    function automatic int bcd_val(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    task automatic check_unit(input int i, input string sfx,
                              input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                              input logic sp, input logic mp, input logic hp, input logic dp,
                              input logic rdy, input logic err);
        chk({"hh", sfx}, h, to_bcd(m_secs[i] / 3600));
        chk({"mm", sfx}, m, to_bcd((m_secs[i] / 60) % 60));
        chk({"ss", sfx}, s, to_bcd(m_secs[i] % 60));
        chk({"sec_pulse", sfx}, sp, m_sp[i]);
        chk({"min_pulse", sfx}, mp, m_mp[i]);
        chk({"hour_pulse", sfx}, hp, m_hp[i]);
        chk({"day_pulse", sfx}, dp, m_dp[i]);
        chk({"load_ready", sfx}, rdy, !m_loading);
        chk({"load_err", sfx}, err, m_err);
    endtask

    task automatic step(input bit r, input bit rn, input bit tk, input bit lv,
                        input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        bit hs, ev;
        rst = r; run = rn; tick = tk;
        lif1.load_valid = lv; lif1.load_hh = h; lif1.load_mm = m; lif1.load_ss = s;
        lif0.load_valid = lv; lif0.load_hh = h; lif0.load_mm = m; lif0.load_ss = s;

        if (r) begin
            for (int i = 0; i < 2; i++) begin
                m_secs[i] = 0; m_sp[i] = 0; m_mp[i] = 0; m_hp[i] = 0; m_dp[i] = 0;
            end
            m_err = 0; m_loading = 0; m_running = 0;
        end else begin
            hs = lv && !m_loading;
            m_err = 0;
            for (int i = 0; i < 2; i++) begin
                m_sp[i] = 0; m_mp[i] = 0; m_hp[i] = 0; m_dp[i] = 0;
            end
            if (m_loading) begin
                if (legal(m_shh, 23) && legal(m_smm, 59) && legal(m_sss, 59)) begin
                    for (int i = 0; i < 2; i++)
                        m_secs[i] = bcd_val(m_shh) * 3600 + bcd_val(m_smm) * 60 + bcd_val(m_sss);
                end else begin
                    m_err = 1;
                end
            end
            for (int i = 0; i < 2; i++) begin
                ev = (i == 1) ? (tk && !m_prev) : (tk != m_prev);
                if (m_running && !m_loading && ev && !hs) begin
                    m_secs[i] = (m_secs[i] + 1) % DAY;
                    m_sp[i] = 1;
                    m_mp[i] = (m_secs[i] % 60) == 0;
                    m_hp[i] = (m_secs[i] % 3600) == 0;
                    m_dp[i] = m_secs[i] == 0;
                end
            end
            if (hs) begin
                m_shh = h; m_smm = m; m_sss = s;
            end
            m_loading = hs;
            m_running = !hs && rn;
        end
        m_prev = tk;

        @(posedge clk);
        #1;
        check_unit(1, "1", hh1, mm1, ss1, sp1, mp1, hp1, dp1, lif1.load_ready, lif1.load_err);
        check_unit(0, "0", hh0, mm0, ss0, sp0, mp0, hp0, dp0, lif0.load_ready, lif0.load_err);
        cnt_sp1  += int'(sp1);
        cnt_sp0  += int'(sp0);
        cnt_mp1  += int'(mp1);
        cnt_err1 += int'(lif1.load_err);
        if (sp1 && mp1 && hp1 && dp1) all_pulses1++;
    endtask

    task automatic idle(input bit rn, input bit tk, input int n);
        for (int k = 0; k < n; k++) step(0, rn, tk, 0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic rises(input bit rn, input int n);
        for (int k = 0; k < n; k++) begin
            idle(rn, 1, 4);
            idle(rn, 0, 4);
        end
    endtask

    task automatic load(input bit rn, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        step(0, rn, 0, 1, h, m, s);
        chk("ready_low_in_load", lif1.load_ready, 1'b0);
        idle(rn, 0, 2);
    endtask

    task automatic clear_counts();
        cnt_sp1 = 0; cnt_sp0 = 0; cnt_mp1 = 0; cnt_err1 = 0; all_pulses1 = 0;
    endtask

    initial begin
        logic [7:0] sv_hh, sv_mm, sv_ss;
        logic [7:0] rh, rm, rs;
        bit rtk, rrn;
        int hold;
        m_prev = 0; m_shh = 0; m_smm = 0; m_sss = 0;
        clear_counts();

        // Reset state
        step(1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        step(1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        chk("rst_hh", hh1, 8'h00);
        chk("rst_ready", lif1.load_ready, 1'b1);
        chk("rst_err", lif1.load_err, 1'b0);

        // Three rising edges while running
        idle(1, 0, 2);
        clear_counts();
        rises(1, 3);
        chk("s1_ss", ss1, 8'h03);
        chk("s1_mm", mm1, 8'h00);
        chk("s1_nsec", cnt_sp1, 3);
        chk("s1_nsec_both", cnt_sp0, 6);

        // Minute carry
        load(1, 8'h00, 8'h00, 8'h58);
        clear_counts();
        rises(1, 2);
        chk("s2_mm", mm1, 8'h01);
        chk("s2_ss", ss1, 8'h00);
        chk("s2_nmin", cnt_mp1, 1);

        // Day wrap with all pulses together
        load(1, 8'h23, 8'h59, 8'h59);
        clear_counts();
        rises(1, 1);
        chk("s3_time", {hh1, mm1, ss1}, 24'h000000);
        chk("s3_all_pulses", all_pulses1, 1);

        // Rejected loads leave time alone
        sv_hh = hh1; sv_mm = mm1; sv_ss = ss1;
        clear_counts();
        load(0, 8'h24, 8'h00, 8'h00);
        load(0, 8'h00, 8'h00, 8'h5A);
        load(0, 8'h00, 8'h60, 8'h00);
        chk("s4_nerr", cnt_err1, 3);
        chk("s4_time", {hh1, mm1, ss1}, {sv_hh, sv_mm, sv_ss});

        // tick high across reset release, then stopped ticks
        step(1, 0, 1, 0, 8'h00, 8'h00, 8'h00);
        step(1, 0, 1, 0, 8'h00, 8'h00, 8'h00);
        clear_counts();
        idle(1, 1, 6);
        chk("s5_ss_release", ss1, 8'h00);
        idle(0, 0, 4);
        clear_counts();
        rises(0, 5);
        chk("s5_ss_held", ss1, 8'h00);
        chk("s5_nsec", cnt_sp1 + cnt_sp0, 0);

        // Reset during the load cycle, then both-edge counting
        step(0, 1, 0, 1, 8'h12, 8'h34, 8'h56);
        step(1, 1, 0, 0, 8'h00, 8'h00, 8'h00);
        chk("s6_time", {hh1, mm1, ss1}, 24'h000000);
        chk("s6_ready", lif1.load_ready, 1'b1);
        step(0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
        chk("s6_err", lif1.load_err, 1'b0);
        chk("s6_time_after", {hh1, mm1, ss1}, 24'h000000);
        idle(1, 0, 1);
        idle(1, 1, 4);
        idle(1, 0, 4);
        chk("s6_ss_both", ss0, 8'h02);
        chk("s6_ss_rise", ss1, 8'h01);

        // Randomized traffic
        rtk = 0; rrn = 1; hold = 1;
        for (int c = 0; c < 4000; c++) begin
            if (--hold == 0) begin
                rtk  = !rtk;
                hold = $urandom_range(1, 6);
            end
            if ($urandom_range(0, 49) == 0) rrn = !rrn;
            case ($urandom_range(0, 3))
                0: begin rh = 8'($urandom); rm = 8'($urandom); rs = 8'($urandom); end
                1: begin
                    rh = to_bcd($urandom_range(0, 23));
                    rm = to_bcd($urandom_range(0, 59));
                    rs = to_bcd($urandom_range(0, 59));
                end
                2: begin rh = 8'h23; rm = 8'h59; rs = to_bcd($urandom_range(55, 59)); end
                default: begin rh = to_bcd($urandom_range(0, 23)); rm = 8'h59; rs = 8'h58; end
            endcase
            step($urandom_range(0, 299) == 0, rrn, rtk, $urandom_range(0, 11) == 0, rh, rm, rs);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
